i2c_target_core: RTL
====================

# i2c_target_core

I2C target (slave) engine: the bus-side counterpart to the team's I2C master core. It responds to a 7-bit address on an open-drain SCL/SDA pair, ACKs or NACKs, and receives write bytes or returns read bytes through valid/ready byte handshakes to a local host or register file. It sits beside the pad ring, using the same `*_pad_i / *_pad_o / *_padoen_o` convention as the master. It never stretches SCL.

## Interface
- `SYNC_STAGES`, default 2: flops in the SCL/SDA input synchronizers; minimum 2.
- `clk_i` in 1: single clock. Must be ≥ 8× SCL frequency.
- `arst_i` in 1: reset, asynchronous and active-high.
- `en_i` in 1: target enable; sampled only at address-byte completion.
- `own_addr_i` in 7: own 7-bit address.
- `scl_pad_i` in 1: SCL from pad.
- `scl_pad_o` out 1: tied 0.
- `scl_padoen_o` out 1: tied 1 (SCL never driven).
- `sda_pad_i` in 1: SDA from pad.
- `sda_pad_o` out 1: tied 0.
- `sda_padoen_o` out 1: 0 = pull SDA low, 1 = release.
- `rx_data_o` out 8: received byte holding register.
- `rx_valid_o` out 1: holding register full.
- `rx_ready_i` in 1: host pop. A transfer occurs when both `rx_valid_o` and `rx_ready_i` are high.
- `tx_data_i` in 8: next read byte.
- `tx_valid_i` in 1: `tx_data_i` is valid.
- `tx_ready_o` out 1: one-cycle pulse when `tx_data_i` is consumed.
- `busy_o` out 1: addressed transaction in progress.
- `rnw_o` out 1: R/W bit of the last matched address.
- `start_o`, `stop_o` out 1: one-cycle pulses on a detected START/Sr and STOP.
- `rx_overflow_o`, `tx_underrun_o` out 1: one-cycle error pulses.

## Operation
- Inputs pass through `SYNC_STAGES` flops plus one history flop for edge detection.
- Bus conditions, evaluated on the synchronized signals:
  - START/Sr: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in any state and take priority over bit events in the same cycle.
- SDA is sampled on each synchronized SCL rising edge. `sda_padoen_o` changes only on a synchronized SCL falling edge, or on START/STOP/reset.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START from any state: go to ADDR, bit counter = 0, release SDA, pulse `start_o`.
- STOP from any state: go to IDLE, release SDA, clear `busy_o`, pulse `stop_o`.
- ADDR: shift in 8 bits MSB-first.
  - On the 8th rise, if `en_i` and bits[7:1] == `own_addr_i`: latch `rnw_o` = bit0, set `busy_o`, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP with SDA released.
  - General call (0x00) is not supported.
- ADDR_ACK: drive SDA low at the next SCL fall. Release it at the following SCL fall.
  - Write (`rnw_o` = 0): go to WR_DATA.
  - Read (`rnw_o` = 1): load the shift register at that same fall, drive its MSB, go to RD_DATA.
- WR_DATA: on the 8th rise, the holding register is free if `rx_valid_o` = 0, or if `rx_valid_o` && `rx_ready_i` in that cycle.
  - Free: load `rx_data_o`, set `rx_valid_o`, ACK.
  - Not free: discard the byte, pulse `rx_overflow_o`, NACK (SDA stays released).
  - Then go to WR_ACK.
- WR_ACK: ACK is driven from the next fall to the following fall. Then return to WR_DATA.
- Read byte load (at the SCL fall that starts the byte):
  - `tx_valid_i` = 1: load `tx_data_i`, pulse `tx_ready_o`.
  - `tx_valid_i` = 0: load 0xFF, pulse `tx_underrun_o`.
- RD_DATA: drive the MSB at the load fall and the next bit at each subsequent fall. After bit 0, release SDA at the next fall and go to RD_ACK.
- RD_ACK: sample the master's ACK on the next rise.
  - 0 (ACK): load the next byte at the following fall.
  - 1 (NACK): go to WAIT_STOP.
- WAIT_STOP: SDA released; ignore bits until STOP or START.
- `en_i` low mid-transfer does not abort the transfer.

## Timing
- Reset values (all asynchronous):
  - FSM = IDLE.
  - `sda_padoen_o` = 1, `scl_padoen_o` = 1.
  - `rx_data_o` = 0x00.
  - `rx_valid_o`, `tx_ready_o`, `busy_o`, `rnw_o`, all pulses = 0.
  - Synchronizer flops = 1 (idle bus).
- Reset mid-transfer releases SDA in the same cycle; no partial byte is retained.
- Pad-to-detect latency: `SYNC_STAGES` + 1 `clk_i` cycles.
- SDA output change lags the pad SCL fall by `SYNC_STAGES` + 2 cycles. This must be less than the SCL low time.
- `rx_valid_o` rises 1 cycle after the detected 8th SCL rise. It clears the cycle after the handshake unless reloaded in that same cycle.
- `tx_ready_o` and all error pulses are exactly 1 cycle wide.

## Test plan
- `own_addr_i` = 0x50; master writes addr 0xA0, data 0xA5, STOP -> ACK on both bytes, `rx_data_o` = 0xA5, `rx_valid_o` = 1, `rnw_o` = 0, `stop_o` pulses, `busy_o` drops.
- Master sends 0xA2 (addr 0x51) -> `sda_padoen_o` stays 1 for the whole transfer, `busy_o` = 0, no rx activity.
- Write 0x11 then 0x22 with `rx_ready_i` = 0 -> 0x11 ACKed, 0x22 NACKed, `rx_overflow_o` pulses once, `rx_data_o` stays 0x11. Repeat with `rx_ready_i` held high -> both ACKed.
- Read addr 0xA1, `tx_data_i` = 0x3C valid, master ACKs; then `tx_valid_i` = 0, master NACKs -> bus shows 0x3C then 0xFF, one `tx_ready_o` and one `tx_underrun_o` pulse, SDA released after the NACK.
- Write 0x7E, then Sr, then addr 0xA1 read -> `start_o` pulses twice, `rnw_o` goes 0 then 1, no `stop_o` between.
- Assert `arst_i` while the target drives ACK low -> `sda_padoen_o` = 1 in the same cycle, FSM returns to IDLE, and the next START + matching address is ACKed normally.

Source files
------------

// File: rtl/i2c_target_core_if.sv
// i2c_target_core_if: byte-level host handshake between the I2C target core and
// a local host or register file.
//   rx_data / rx_valid / rx_ready : received-byte holding register, popped by the host
//   tx_data / tx_valid / tx_ready : next read byte, tx_ready pulses when it is consumed
// Modports: slave = target core side, master = host side.
interface i2c_target_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/i2c_target_core.sv
// i2c_target_core: 7-bit-address I2C target engine. Never stretches SCL.
// Ports:
//   clk_i, arst_i            : clock (>= 8x SCL), asynchronous active-high reset
//   en_i, own_addr_i         : enable (sampled at address completion), own address
//   scl_pad_* / sda_pad_*    : open-drain pad triplets; only sda_padoen_o ever toggles
//   host                     : byte handshake (i2c_target_core_if.slave)
//   busy_o, rnw_o            : addressed transaction in progress, R/W bit of last match
//   start_o, stop_o          : one-cycle pulses on START/Sr and STOP
//   rx_overflow_o            : written byte dropped because the holding register was full
//   tx_underrun_o            : read byte requested with no tx_valid, 0xFF sent instead
module i2c_target_core #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     en_i,
    input  logic [6:0]               own_addr_i,
    input  logic                     scl_pad_i,
    output logic                     scl_pad_o,
    output logic                     scl_padoen_o,
    input  logic                     sda_pad_i,
    output logic                     sda_pad_o,
    output logic                     sda_padoen_o,
    i2c_target_core_if.slave         host,
    output logic                     busy_o,
    output logic                     rnw_o,
    output logic                     start_o,
    output logic                     stop_o,
    output logic                     rx_overflow_o,
    output logic                     tx_underrun_o
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StAddr     = 3'd1;
    localparam logic [2:0] StAddrAck  = 3'd2;
    localparam logic [2:0] StWrData   = 3'd3;
    localparam logic [2:0] StWrAck    = 3'd4;
    localparam logic [2:0] StRdData   = 3'd5;
    localparam logic [2:0] StRdAck    = 3'd6;
    localparam logic [2:0] StWaitStop = 3'd7;

    // Synchronizers, history flops and registered bus events
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_hist_q, sda_hist_q;
    logic scl_s, sda_s;
    logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_bit_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_pad_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_pad_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
            scl_rise_q <= scl_s & ~scl_hist_q;
            scl_fall_q <= ~scl_s & scl_hist_q;
            // SCL must be high on both sides of the SDA edge
            start_q    <= scl_s & scl_hist_q & sda_hist_q & ~sda_s;
            stop_q     <= scl_s & scl_hist_q & ~sda_hist_q & sda_s;
            sda_bit_q  <= sda_s;
        end
    end

    // Protocol FSM
    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oen_q, sda_oen_d;
    logic       phase_q, phase_d;     // ACK slot: 0 = before drive fall, 1 = in slot
    logic       ack_q, ack_d;         // write byte is to be ACKed
    logic       busy_q, busy_d, rnw_q, rnw_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ready_q, tx_ready_d, ovf_q, ovf_d, und_q, und_d;
    logic       rx_pop, load_tx;
    logic [7:0] shifted, tx_byte;

    assign rx_pop  = rx_valid_q & host.rx_ready;
    assign shifted = {shift_q[6:0], sda_bit_q};
    assign tx_byte = host.tx_valid ? host.tx_data : 8'hFF;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sda_oen_d  = sda_oen_q;
        phase_d    = phase_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        rnw_d      = rnw_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_pop;
        tx_ready_d = 1'b0;
        ovf_d      = 1'b0;
        und_d      = 1'b0;
        load_tx    = 1'b0;

        if (start_q) begin
            state_d   = StAddr;
            cnt_d     = 3'd0;
            sda_oen_d = 1'b1;
        end else if (stop_q) begin
            state_d   = StIdle;
            sda_oen_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                StAddr: if (scl_rise_q) begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (en_i && shifted[7:1] == own_addr_i) begin
                            rnw_d   = shifted[0];
                            busy_d  = 1'b1;
                            phase_d = 1'b0;
                            state_d = StAddrAck;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end
                end
                StAddrAck: if (scl_fall_q) begin
                    if (!phase_q) begin
                        sda_oen_d = 1'b0;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (rnw_q) begin
                            load_tx = 1'b1;
                        end else begin
                            sda_oen_d = 1'b1;
                            cnt_d     = 3'd0;
                            state_d   = StWrData;
                        end
                    end
                end
                StWrData: if (scl_rise_q) begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (!rx_valid_q || rx_pop) begin
                            rx_data_d  = shifted;
                            rx_valid_d = 1'b1;
                            ack_d      = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                            ack_d = 1'b0;
                        end
                        phase_d = 1'b0;
                        state_d = StWrAck;
                    end
                end
                StWrAck: if (scl_fall_q) begin
                    if (!phase_q) begin
                        sda_oen_d = ~ack_q;
                        phase_d   = 1'b1;
                    end else begin
                        sda_oen_d = 1'b1;
                        phase_d   = 1'b0;
                        cnt_d     = 3'd0;
                        state_d   = StWrData;
                    end
                end
                StRdData: if (scl_fall_q) begin
                    if (cnt_q != 3'd7) begin
                        shift_d   = {shift_q[6:0], 1'b1};
                        sda_oen_d = shift_q[6];
                        cnt_d     = cnt_q + 3'd1;
                    end else begin
                        sda_oen_d = 1'b1;
                        phase_d   = 1'b0;
                        state_d   = StRdAck;
                    end
                end
                StRdAck: begin
                    if (scl_rise_q) begin
                        if (sda_bit_q) state_d = StWaitStop;
                        else           phase_d = 1'b1;
                    end else if (scl_fall_q && phase_q) begin
                        phase_d = 1'b0;
                        load_tx = 1'b1;
                    end
                end
                default: ;  // StIdle, StWaitStop: wait for START/STOP
            endcase
        end

        // Read byte load: MSB goes on the bus at the same fall
        if (load_tx) begin
            shift_d    = tx_byte;
            sda_oen_d  = tx_byte[7];
            tx_ready_d = host.tx_valid;
            und_d      = ~host.tx_valid;
            cnt_d      = 3'd0;
            state_d    = StRdData;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            sda_oen_q  <= 1'b1;
            phase_q    <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            rnw_q      <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sda_oen_q  <= sda_oen_d;
            phase_q    <= phase_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            rnw_q      <= rnw_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            ovf_q      <= ovf_d;
            und_q      <= und_d;
        end
    end

    assign scl_pad_o     = 1'b0;
    assign scl_padoen_o  = 1'b1;
    assign sda_pad_o     = 1'b0;
    assign sda_padoen_o  = sda_oen_q;
    assign host.rx_data  = rx_data_q;
    assign host.rx_valid = rx_valid_q;
    assign host.tx_ready = tx_ready_q;
    assign busy_o        = busy_q;
    assign rnw_o         = rnw_q;
    assign start_o       = start_q;
    assign stop_o        = stop_q;
    assign rx_overflow_o = ovf_q;
    assign tx_underrun_o = und_q;

endmodule
